// File: rtl/tnn_feature_framer.sv
// tnn_feature_framer: quantises a 7-beat raw feature stream into a held
// 7x2-bit vector for the classifier, flagging short/long frames.
module tnn_feature_framer #(
  parameter int unsigned FEAT_W = 8,
  parameter int unsigned T1     = 64,
  parameter int unsigned T2     = 128,
  parameter int unsigned T3     = 192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        input_a,
  output logic [1:0]        input_b,
  output logic [1:0]        input_c,
  output logic [1:0]        input_d,
  output logic [1:0]        input_e,
  output logic [1:0]        input_f,
  output logic [1:0]        input_g,
  output logic              err_frame,
  output logic [15:0]       frame_cnt
);

  typedef enum logic {
    COLLECT = 1'b0,
    RESYNC  = 1'b1
  } state_t;

  localparam logic [FEAT_W-1:0] TH1 = FEAT_W'(T1);
  localparam logic [FEAT_W-1:0] TH2 = FEAT_W'(T2);
  localparam logic [FEAT_W-1:0] TH3 = FEAT_W'(T3);

  state_t      state;
  logic [2:0]  idx;
  logic [1:0]  asm_q [6];
  logic [1:0]  out_q [7];
  logic [1:0]  q;
  logic        ready_en;
  logic        last_slot;
  logic        stall;
  logic        accept;

  always_comb begin
    q = 2'd0;
    if (s_data >= TH3)      q = 2'd3;
    else if (s_data >= TH2) q = 2'd2;
    else if (s_data >= TH1) q = 2'd1;
  end

  // Stall only the completing beat while the held vector is still unconsumed.
  assign last_slot = (idx == 3'd6);
  assign stall     = (state == COLLECT) && last_slot && m_valid && !m_ready;
  assign s_ready   = ready_en && !stall;
  assign accept    = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= '0;
      err_frame <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) asm_q[i] <= '0;
    end else begin
      err_frame <= 1'b0;
      if (accept) begin
        case (state)
          COLLECT: begin
            if (!last_slot) begin
              if (s_last) begin
                err_frame <= 1'b1;
                idx       <= '0;
              end else begin
                for (int unsigned i = 0; i < 6; i++)
                  if (idx == 3'(i)) asm_q[i] <= q;
                idx <= idx + 3'd1;
              end
            end else begin
              idx <= '0;
              if (!s_last) begin
                err_frame <= 1'b1;
                state     <= RESYNC;
              end
            end
          end
          RESYNC: begin
            if (s_last) begin
              state <= COLLECT;
              idx   <= '0;
            end
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

  // Deliver on a good 7th beat; the delivery write wins over a same-cycle consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      frame_cnt <= '0;
      for (int unsigned i = 0; i < 7; i++) out_q[i] <= '0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (accept && (state == COLLECT) && last_slot && s_last) begin
        for (int unsigned i = 0; i < 6; i++) out_q[i] <= asm_q[i];
        out_q[6]  <= q;
        m_valid   <= 1'b1;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign input_a = out_q[0];
  assign input_b = out_q[1];
  assign input_c = out_q[2];
  assign input_d = out_q[3];
  assign input_e = out_q[4];
  assign input_f = out_q[5];
  assign input_g = out_q[6];

endmodule

// File: tb/tb_tnn_feature_framer.sv
// Scoreboard bench for tnn_feature_framer with directed, hand-quantised frames.
module tb_tnn_feature_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [1:0] input_a, input_b, input_c, input_d, input_e, input_f, input_g;
  logic       err_frame;
  logic [15:0] frame_cnt;

  tnn_feature_framer #(.FEAT_W(8), .T1(64), .T2(128), .T3(192)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .input_a   (input_a),
    .input_b   (input_b),
    .input_c   (input_c),
    .input_d   (input_d),
    .input_e   (input_e),
    .input_f   (input_f),
    .input_g   (input_g),
    .err_frame (err_frame),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic [15:0] exp_cnt = '0;
  logic [29:0] sb_q [$];

  // Frames: 7 raw bytes (first beat in MSB) with hand-quantised slots (slot 0 in MSB).
  localparam logic [55:0] FA_D = {8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd255};
  localparam logic [13:0] FA_Q = {2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
  localparam logic [55:0] FB_D = {8'd200, 8'd150, 8'd100, 8'd50, 8'd192, 8'd128, 8'd63};
  localparam logic [13:0] FB_Q = {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd0};
  localparam logic [55:0] FC_D = {8'd255, 8'd254, 8'd193, 8'd129, 8'd65, 8'd1, 8'd64};
  localparam logic [13:0] FC_Q = {2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
  localparam logic [55:0] FD_D = {8'd191, 8'd127, 8'd63, 8'd192, 8'd128, 8'd64, 8'd0};
  localparam logic [13:0] FD_Q = {2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};

  function automatic logic [13:0] out_vec();
    return {input_a, input_b, input_c, input_d, input_e, input_f, input_g};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every output handshake; count error pulses.
  always @(negedge clk) begin : mon
    logic [29:0] e;
    if (err_frame) err_seen++;
    if (rst_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vector: got 0x%0h with frame_cnt 0x%0h, none expected",
                 out_vec(), frame_cnt);
      end else begin
        e = sb_q.pop_front();
        check("vector", 32'(out_vec()), 32'(e[29:16]));
        check("frame_cnt", 32'(frame_cnt), 32'(e[15:0]));
      end
    end
  end

  // Drive one beat after a posedge, hold until accepted, return just after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: got s_ready=0 for %0d cycles, required 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [55:0] d, input logic [13:0] q_exp);
    exp_cnt = exp_cnt + 16'd1;
    sb_q.push_back({q_exp, exp_cnt});
    for (int i = 0; i < 7; i++) send_beat(d[8*(6-i) +: 8], i == 6);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_err", 32'(err_frame), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    check("rst_vec", 32'(out_vec()), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("s_ready_before_edge", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1 check("s_ready_after_edge", 32'(s_ready), 32'd1);

    // Threshold boundaries, one-cycle latency, clear after consume.
    send_frame(FA_D, FA_Q);
    check("latency_m_valid", 32'(m_valid), 32'd1);
    idle(1);
    check("m_valid_cleared", 32'(m_valid), 32'd0);

    // Backpressure: hold first vector, stall the 7th beat, then no-bubble handover.
    m_ready = 1'b0;
    send_frame(FB_D, FB_Q);
    fork
      send_frame(FC_D, FC_Q);
    join_none
    idle(10);
    @(negedge clk);
    check("stall_s_ready", 32'(s_ready), 32'd0);
    check("held_vector", 32'(out_vec()), 32'(FB_Q));
    check("held_m_valid", 32'(m_valid), 32'd1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("no_bubble_m_valid", 32'(m_valid), 32'd1);
    check("no_bubble_vector", 32'(out_vec()), 32'(FC_Q));
    wait fork;
    idle(3);

    // Short frame: s_last on beat 4.
    err_exp++;
    for (int i = 0; i < 4; i++) send_beat(8'(10 + 60 * i), i == 3);
    idle(2);
    check("short_no_m_valid", 32'(m_valid), 32'd0);
    check("short_err_count", 32'(err_seen), 32'(err_exp));
    send_frame(FD_D, FD_Q);
    idle(3);

    // Long frame: 9 beats, s_last on beat 9.
    err_exp++;
    for (int i = 0; i < 9; i++) send_beat(8'(25 * i), i == 8);
    idle(2);
    check("long_no_m_valid", 32'(m_valid), 32'd0);
    check("long_err_count", 32'(err_seen), 32'(err_exp));
    send_frame(FA_D, FA_Q);
    idle(3);

    // Reset mid-frame after 3 beats.
    for (int i = 0; i < 3; i++) send_beat(8'(200 + i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_vec", 32'(out_vec()), 32'd0);
    check("midrst_err", 32'(err_frame), 32'd0);
    sb_q.delete();
    exp_cnt = '0;
    idle(2);
    #2 rst_n = 1'b1;
    idle(1);
    send_frame(FB_D, FB_Q);
    idle(3);

    // Counter wrap.
    force dut.frame_cnt = 16'hFFFF;
    #1 release dut.frame_cnt;
    exp_cnt = 16'hFFFF;
    #1 check("forced_cnt", 32'(frame_cnt), 32'h0000FFFF);
    idle(1);
    send_frame(FC_D, FC_Q);

    for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(posedge clk);
    idle(2);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("final_err_count", 32'(err_seen), 32'(err_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
